// File: rtl/uart_pkg.sv
// Shared UART types: divisor width and the divisor latch type used by the
// baud generator, TX/RX shifters and the register file.
package uart_pkg;

  localparam int DIV_W = 16;

  typedef logic [DIV_W-1:0] divisor_t;

endpackage

// File: rtl/uart_baud_generator.sv
// 16550-style baud tick generator: one-cycle pulse on baud_clk every
// {DLH, DLL} clock cycles, used downstream as a clock-enable.
module uart_baud_generator
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] DLL,
  input  logic [7:0] DLH,
  output logic       baud_clk
);

  divisor_t divisor;
  divisor_t term;
  divisor_t cnt;

  // Divisor is read live; a shrink below the current count fires on the next edge.
  assign divisor = {DLH, DLL};
  assign term    = divisor - divisor_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      baud_clk <= 1'b0;
    end else if (!en || divisor == '0) begin
      cnt      <= '0;
      baud_clk <= 1'b0;
    end else if (cnt >= term) begin
      cnt      <= '0;
      baud_clk <= 1'b1;
    end else begin
      cnt      <= cnt + divisor_t'(1);
      baud_clk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_generator.sv
// Scoreboard bench for uart_baud_generator: an edge-counting reference model
// queues the expected baud_clk per edge, a monitor pops and compares.
module tb_uart_baud_generator;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic [7:0] DLL   = 8'd0;
  logic [7:0] DLH   = 8'd0;
  logic       baud_clk;

  int checks = 0;
  int errors = 0;

  bit     exp_q[$];
  longint edge_n  = 0;
  longint start_n = 0;

  always #5 clk = ~clk;

  uart_baud_generator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .DLL      (DLL),
    .DLH      (DLH),
    .baud_clk (baud_clk)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t edge=%0d actual=%b required=%b", name, $time, edge_n, act, exp);
    end
  endtask

  // Reference model: a period starts at reset/disable/divisor-0 or at a pulse;
  // the pulse is due once at least `divisor` edges have elapsed since that start.
  always @(posedge clk) begin
    int unsigned d;
    longint      k;
    bit          e;
    d = {DLH, DLL};
    edge_n++;
    if (!rst_n || !en || d == 0) begin
      e       = 1'b0;
      start_n = edge_n;
    end else begin
      k = edge_n - start_n;
      if (k >= longint'(d)) begin
        e       = 1'b1;
        start_n = edge_n;
      end else begin
        e = 1'b0;
      end
    end
    exp_q.push_back(e);
  end

  // Monitor
  always @(posedge clk) begin
    bit e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("baud_clk", baud_clk, e);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_div(input logic [15:0] d);
    {DLH, DLL} = d;
  endtask

  initial begin
    bit found;
    #1 rst_n = 1'b0;
    #1 check("reset_async", baud_clk, 1'b0);
    set_div(16'h0A2C);
    en = 1'b1;
    cyc(2);
    check("reset_hold", baud_clk, 1'b0);
    rst_n = 1'b1;
    cyc(2 * 2604 + 10);

    // disable window, then a fresh period
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(2604 + 10);

    // divisor 1: constant high; async reset clears it between edges
    set_div(16'd1);
    cyc(20);
    #2 rst_n = 1'b0;
    #1 check("async_clear_div1", baud_clk, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);

    set_div(16'd2);
    cyc(20);
    set_div(16'd0);
    cyc(100);

    // divisor change: 100 -> 20 at cnt ~50, then 20 -> 100 at cnt 5
    set_div(16'd100);
    cyc(150);
    set_div(16'd20);
    cyc(60);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (baud_clk) begin
        found = 1'b1;
        break;
      end
    end
    check("found_pulse_div20", found, 1'b1);
    cyc(5);
    set_div(16'd100);
    cyc(110);

    // async reset mid-count at divisor 2604
    set_div(16'h0A2C);
    en = 1'b0;
    cyc(1);
    en = 1'b1;
    cyc(1000);
    #2 rst_n = 1'b0;
    #1 check("async_clear_mid", baud_clk, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2610);

    // randomized enable / small divisors with live changes
    repeat (40) begin
      en = ($urandom_range(0, 9) != 0);
      set_div(16'($urandom_range(0, 12)));
      cyc($urandom_range(1, 25));
    end

    // max divisor: one full period from a fresh start
    en = 1'b0;
    cyc(1);
    set_div(16'hFFFF);
    en = 1'b1;
    cyc(65535 + 5);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
